key_event_sched: RTL
====================

# key_event_sched

Collects one-cycle press pulses and debounced levels from the per-key debouncers and turns them into a single ordered event stream for the downstream consumer (menu/display control). Pending presses are held per key and served fairly by a round-robin arbiter over a valid/ready handshake. Optionally, a long-press (hold) event is generated per key. Sits directly after the debounce stage; it is the only consumer of the debouncer outputs.

## Interface
- N_KEYS, 2, number of debounced key channels (2..8)
- LONG_CNT, 100_000_000, hold cycles for a long press (2 s at 50 MHz)
- CNT_W, 27, hold counter width; must satisfy 2^CNT_W > LONG_CNT
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_en  input  N_KEYS  one-cycle press pulse per key (debounced flag AND pressed)
- key_state  input  N_KEYS  debounced level per key, 0 = pressed, 1 = released
- evt_valid  output  1  event presented
- evt_ready  input  1  consumer accepts event
- evt_key  output  $clog2(N_KEYS) (min 1)  index of key owning the event
- evt_long  output  1  1 = long-press event, 0 = short press
- evt_drop  output  1  one-cycle pulse: an event was lost because its slot was already pending

## Operation
- Per key: pend_s bit (press) and pend_l bit (long press). key_en[i] sets pend_s[i]. If pend_s[i] is already set and is not being accepted this cycle, the event is lost and evt_drop pulses.
- FSM states:
  - IDLE: if any pend bit is set, select the first requesting key at or after rr_ptr (wrapping) and load evt_key/evt_long. Serve pend_s before pend_l within a key. Go to OFFER.
  - OFFER: evt_valid=1 and evt_key/evt_long held stable until evt_valid&evt_ready. On accept, clear the served bit, set rr_ptr = served key + 1 (mod N_KEYS), and return to IDLE.
- Simultaneous accept and new key_en on the same key/kind: the served bit clears and the new event re-sets it. There is no drop.
- Simultaneous key_en on several keys: all are captured in the same cycle. The order of service is round-robin from rr_ptr.
- A key is never granted twice in a row while another key is requesting.

## Timing
- Reset: evt_valid=0, evt_key=0, evt_long=0, evt_drop=0. All pend bits 0, rr_ptr=0, hold counters 0, FSM in IDLE.
- Latency with the FSM in IDLE:
  - key_en high in cycle t → pend_s set at edge t+1.
  - evt_valid=1 from edge t+2.
- Throughput: at most one event every 2 cycles (OFFER→IDLE→OFFER).
- evt_drop is registered: it pulses in the cycle after the losing key_en.
- If rst_n is asserted mid-OFFER, the offered event and all pending events are discarded immediately.

## Configuration
- KEY_LONG_PRESS_EN defined:
  - Per-key hold counter, cleared on key_en[i]. It increments while key_state[i]==0 and clears when key_state[i]==1.
  - When the count reaches LONG_CNT-1, pend_l[i] is set once and the counter saturates, so there is no repeat until release.
  - If pend_l[i] is already pending when set again, evt_drop pulses.
- KEY_LONG_PRESS_EN undefined: no counters, pend_l is constant 0, and evt_long is tied to 0. Short-press behaviour is identical to the defined case.

## Structure
- Shared package key_pkg: FSM state enum (IDLE, OFFER), constants KEY_PRESSED=1'b0 and KEY_RELEASED=1'b1.
- Sub-module key_hold_timer (one instance per key, generated only under KEY_LONG_PRESS_EN). Ports: clk, rst_n, key_en, key_state → one-cycle long_pulse.

## Test plan
- Short press, ready held high: key_en[0] pulse at cycle 10 → evt_valid at 12, evt_key=0, evt_long=0. Accepted at 12; evt_valid=0 at 13.
- Same-cycle presses, N_KEYS=2, rr_ptr=0, ready high: key_en=2'b11 → events key 0 then key 1, two cycles apart. No drop.
- Backpressure: evt_ready=0 for 20 cycles during OFFER → evt_key/evt_long stable. A second key_en[0] during this time → evt_drop pulses once, and only one key-0 event is delivered.
- Fairness: key 0 pressed every 4 cycles, key 1 pressed once → key 1 is served immediately after the current key-0 event.
- Long press (macro on, LONG_CNT=50): press key 1, hold 60 cycles → short event, then a long event (evt_long=1) about 50 cycles after the press, only once. A release at 40 cycles produces no long event.
- Reset mid-OFFER: rst_n low for 3 cycles → evt_valid=0 at once. No event after release of reset without a new key_en.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the key event scheduler.
// Hold timers are only built when KEY_LONG_PRESS_EN is defined.
package key_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // A single key still needs a 1-bit index.
  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_sched_if.sv
// Event stream from the scheduler to the menu/display consumer.
interface key_event_sched_if
  import key_pkg::*;
#(
  parameter int N_KEYS = 2
);
  localparam int KEY_W = key_w(N_KEYS);

  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic             evt_long;
  logic             evt_drop;

  modport master (output evt_valid, evt_key, evt_long, evt_drop, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_long, evt_drop, output evt_ready);
endinterface

// File: rtl/key_hold_timer.sv
// Per-key hold counter; emits one long_pulse per continuous press.
// Only instantiated when KEY_LONG_PRESS_EN is defined.
module key_hold_timer
  import key_pkg::*;
#(
  parameter int LONG_CNT = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_en,
  input  logic key_state,
  output logic long_pulse
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (key_en || key_state == KEY_RELEASED) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(LONG_CNT - 1)) begin
        // Saturating at LONG_CNT-1 suppresses repeats until release.
        cnt        <= cnt + CNT_W'(1);
        long_pulse <= (cnt == CNT_W'(LONG_CNT - 2));
      end
    end
  end

endmodule

// File: rtl/key_event_sched.sv
// Round-robin scheduler merging per-key press (and optional long-press)
// events into one valid/ready stream. Long press: define KEY_LONG_PRESS_EN.
module key_event_sched
  import key_pkg::*;
#(
  parameter int N_KEYS   = 2,
  parameter int LONG_CNT = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_en,
  input  logic [N_KEYS-1:0] key_state,
  key_event_sched_if.master evt
);

  localparam int KEY_W = key_w(N_KEYS);

  state_e            state;
  logic [KEY_W-1:0]  rr_ptr;
  logic [N_KEYS-1:0] pend_s, pend_l, long_pulse;
  logic [N_KEYS-1:0] clr_s, clr_l, drop_s, drop_l, req;
  logic [KEY_W-1:0]  sel_key;
  logic              sel_found, sel_long, accept;

  assign accept = (state == OFFER) && evt.evt_ready;

  always_comb begin
    clr_s = '0;
    clr_l = '0;
    if (accept) begin
      if (evt.evt_long) clr_l[evt.evt_key] = 1'b1;
      else              clr_s[evt.evt_key] = 1'b1;
    end
  end

  // A new event only collides with a slot that is not being served now.
  assign drop_s = key_en & pend_s & ~clr_s;
  assign drop_l = long_pulse & pend_l & ~clr_l;
  assign req    = pend_s | pend_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s       <= '0;
      evt.evt_drop <= 1'b0;
    end else begin
      pend_s       <= key_en | (pend_s & ~clr_s);
      evt.evt_drop <= |{drop_s, drop_l};
    end
  end

`ifdef KEY_LONG_PRESS_EN
  for (genvar i = 0; i < N_KEYS; i++) begin : g_hold
    key_hold_timer #(.LONG_CNT(LONG_CNT), .CNT_W(CNT_W)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_en    (key_en[i]),
      .key_state (key_state[i]),
      .long_pulse(long_pulse[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_l <= '0;
    else        pend_l <= long_pulse | (pend_l & ~clr_l);
  end

  // Short press is served before long press within a key.
  assign sel_long = ~pend_s[sel_key];
`else
  logic unused_cfg;
  assign long_pulse = '0;
  assign pend_l     = '0;
  assign sel_long   = 1'b0;
  assign unused_cfg = ^{key_state, CNT_W'(LONG_CNT)};
`endif

  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_key   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_KEYS) idx = idx - N_KEYS;
      if (!sel_found && req[idx[KEY_W-1:0]]) begin
        sel_found = 1'b1;
        sel_key   = KEY_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_long  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_found) begin
          state         <= OFFER;
          evt.evt_valid <= 1'b1;
          evt.evt_key   <= sel_key;
          evt.evt_long  <= sel_long;
        end
        OFFER: if (evt.evt_ready) begin
          state         <= IDLE;
          evt.evt_valid <= 1'b0;
          rr_ptr        <= (evt.evt_key == KEY_W'(N_KEYS - 1)) ? '0
                                                               : evt.evt_key + KEY_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
